// File: rtl/itch_msg_framer_pkg.sv
// Shared ITCH framing definitions: capture sizing, framer FSM states and
// ITCH message type codes for the order book stage.
package itch_msg_framer_pkg;

  localparam int MAX_ITCH_MSG_BYTES = 50;
  localparam int ITCH_IDLE_TIMEOUT  = 64;

  typedef enum logic [1:0] {
    LEN_HI = 2'd0,
    LEN_LO = 2'd1,
    BODY   = 2'd2,
    EMIT   = 2'd3
  } itchFramerStateType;

  localparam logic [7:0] ITCH_TYPE_ADD_ORDER    = 8'h41; // 'A'
  localparam logic [7:0] ITCH_TYPE_DELETE_ORDER = 8'h44; // 'D'
  localparam logic [7:0] ITCH_TYPE_EXECUTED     = 8'h45; // 'E'
  localparam logic [7:0] ITCH_TYPE_CANCEL       = 8'h58; // 'X'
  localparam logic [7:0] ITCH_TYPE_REPLACE      = 8'h55; // 'U'
  localparam logic [7:0] ITCH_TYPE_SYSTEM_EVENT = 8'h53; // 'S'

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      satInc16 = value;
    end else begin
      satInc16 = value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/itch_msg_framer.sv
// Splits the gated MoldUDP64 payload into length-prefixed ITCH messages and
// emits each one as a single registered wide word with status flags and counters.
module itch_msg_framer
  import itch_msg_framer_pkg::*;
#(
  parameter int MAX_MSG_BYTES = MAX_ITCH_MSG_BYTES,
  parameter int IDLE_TIMEOUT  = ITCH_IDLE_TIMEOUT
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic                       itchDataValidIn,
  input  logic [7:0]                 itchDataIn,
  input  logic                       packetLostIn,
  output logic                       msgValidOut,
  output logic [7:0]                 msgTypeOut,
  output logic [15:0]                msgLenOut,
  output logic [MAX_MSG_BYTES*8-1:0] msgDataOut,
  output logic                       msgTruncOut,
  output logic                       msgSeqGapOut,
  output logic [31:0]                msgCntOut,
  output logic [15:0]                abortCntOut
);

  localparam int DATA_W = MAX_MSG_BYTES * 8;
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_MSG_BYTES);

  itchFramerStateType stateR, nextStateS;

  logic [15:0]       lenR;
  logic [15:0]       byteIdxR;
  logic [15:0]       idleCntR;
  logic [DATA_W-1:0] dataR;
  logic              gapLatchR;

  logic loadHiS, loadLoS, startBodyS, storeByteS;
  logic emitS, abortS, idleTickS, idleClrS, timeoutS;

  // State register
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      stateR <= LEN_HI;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    nextStateS = stateR;
    loadHiS    = 1'b0;
    loadLoS    = 1'b0;
    startBodyS = 1'b0;
    storeByteS = 1'b0;
    emitS      = 1'b0;
    abortS     = 1'b0;
    idleTickS  = 1'b0;
    idleClrS   = 1'b0;
    timeoutS   = (idleCntR == IDLE_LAST);
    case (stateR)
      LEN_HI: begin
        idleClrS = 1'b1;
        if (itchDataValidIn) begin
          loadHiS    = 1'b1;
          nextStateS = LEN_LO;
        end else begin
          nextStateS = LEN_HI;
        end
      end
      LEN_LO: begin
        if (itchDataValidIn) begin
          idleClrS = 1'b1;
          loadLoS  = 1'b1;
          if ({lenR[15:8], itchDataIn} == 16'h0000) begin
            abortS     = 1'b1;
            nextStateS = LEN_HI;
          end else begin
            startBodyS = 1'b1;
            nextStateS = BODY;
          end
        end else if (timeoutS) begin
          abortS     = 1'b1;
          idleClrS   = 1'b1;
          nextStateS = LEN_HI;
        end else begin
          idleTickS = 1'b1;
        end
      end
      BODY: begin
        if (itchDataValidIn) begin
          idleClrS   = 1'b1;
          storeByteS = 1'b1;
          if (byteIdxR == (lenR - 16'd1)) begin
            nextStateS = EMIT;
          end else begin
            nextStateS = BODY;
          end
        end else if (timeoutS) begin
          abortS     = 1'b1;
          idleClrS   = 1'b1;
          nextStateS = LEN_HI;
        end else begin
          idleTickS = 1'b1;
        end
      end
      EMIT: begin
        // A byte arriving here is already the next message's length MSB
        emitS    = 1'b1;
        idleClrS = 1'b1;
        if (itchDataValidIn) begin
          loadHiS    = 1'b1;
          nextStateS = LEN_LO;
        end else begin
          nextStateS = LEN_HI;
        end
      end
      default: begin
        idleClrS   = 1'b1;
        nextStateS = LEN_HI;
      end
    endcase
  end

  // Length, byte index, idle counter and capture register
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      lenR     <= 16'h0000;
      byteIdxR <= 16'h0000;
      idleCntR <= 16'h0000;
      dataR    <= '0;
    end else begin
      if (loadHiS) begin
        lenR[15:8] <= itchDataIn;
      end
      if (loadLoS) begin
        lenR[7:0] <= itchDataIn;
      end
      if (startBodyS) begin
        dataR    <= '0;
        byteIdxR <= 16'h0000;
      end else if (storeByteS) begin
        for (int k = 0; k < MAX_MSG_BYTES; k++) begin
          if (byteIdxR == 16'(k)) begin
            dataR[(MAX_MSG_BYTES-1-k)*8 +: 8] <= itchDataIn;
          end
        end
        byteIdxR <= byteIdxR + 16'd1;
      end
      if (idleClrS) begin
        idleCntR <= 16'h0000;
      end else if (idleTickS) begin
        idleCntR <= idleCntR + 16'd1;
      end
    end
  end

  // Sequence-gap latch: an emit coinciding with a new pulse reports the old value
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      gapLatchR <= 1'b0;
    end else if (emitS) begin
      gapLatchR <= packetLostIn;
    end else if (packetLostIn) begin
      gapLatchR <= 1'b1;
    end
  end

  // Registered message outputs and counters
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      msgValidOut  <= 1'b0;
      msgTypeOut   <= 8'h00;
      msgLenOut    <= 16'h0000;
      msgDataOut   <= '0;
      msgTruncOut  <= 1'b0;
      msgSeqGapOut <= 1'b0;
      msgCntOut    <= 32'h0000_0000;
      abortCntOut  <= 16'h0000;
    end else begin
      msgValidOut <= emitS;
      if (emitS) begin
        msgTypeOut   <= dataR[DATA_W-1 -: 8];
        msgLenOut    <= lenR;
        msgDataOut   <= dataR;
        msgTruncOut  <= (lenR > MAX_LEN);
        msgSeqGapOut <= gapLatchR;
        msgCntOut    <= msgCntOut + 32'd1;
      end
      if (abortS) begin
        abortCntOut <= satInc16(abortCntOut);
      end
    end
  end

endmodule

// File: tb/tb_itch_msg_framer.sv
// Randomized bench for itch_msg_framer: a transaction-level model predicts each
// emitted message (fields, latency, count) from the driven message list.
module tb_itch_msg_framer;
  import itch_msg_framer_pkg::*;

  localparam int MAXB = 50;
  localparam int TMO  = 64;
  localparam int DW   = MAXB * 8;

  logic          clkIn = 1'b0;
  logic          rstIn = 1'b1;
  logic          itchDataValidIn = 1'b0;
  logic [7:0]    itchDataIn = 8'h00;
  logic          packetLostIn = 1'b0;
  logic          msgValidOut;
  logic [7:0]    msgTypeOut;
  logic [15:0]   msgLenOut;
  logic [DW-1:0] msgDataOut;
  logic          msgTruncOut;
  logic          msgSeqGapOut;
  logic [31:0]   msgCntOut;
  logic [15:0]   abortCntOut;

  itch_msg_framer #(.MAX_MSG_BYTES(MAXB), .IDLE_TIMEOUT(TMO)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .itchDataValidIn(itchDataValidIn),
    .itchDataIn(itchDataIn), .packetLostIn(packetLostIn),
    .msgValidOut(msgValidOut), .msgTypeOut(msgTypeOut), .msgLenOut(msgLenOut),
    .msgDataOut(msgDataOut), .msgTruncOut(msgTruncOut), .msgSeqGapOut(msgSeqGapOut),
    .msgCntOut(msgCntOut), .abortCntOut(abortCntOut)
  );

  always #5 clkIn = ~clkIn;

  int cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]    typ;
    logic [15:0]   len;
    logic [DW-1:0] data;
    logic          trunc;
    logic          gap;
    int            cnt;
    int            cyc;
  } expMsgT;

  expMsgT expQ[$];
  int     msgExp = 0;
  int     abortExp = 0;
  bit     gapPend = 1'b0;
  logic [7:0] types [6] = '{8'h41, 8'h44, 8'h45, 8'h58, 8'h55, 8'h53};

  task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every emitted message against the head of the expected queue
  always @(negedge clkIn) begin
    if (!rstIn && msgValidOut) begin
      if (expQ.size() == 0) begin
        checkVal("spurious emit", 1, 0);
      end else begin
        expMsgT e;
        e = expQ.pop_front();
        checkVal("latency", cyc, e.cyc);
        checkVal("msgType", msgTypeOut, e.typ);
        checkVal("msgLen", msgLenOut, e.len);
        checkVal("msgData", msgDataOut, e.data);
        checkVal("msgTrunc", msgTruncOut, e.trunc);
        checkVal("msgSeqGap", msgSeqGapOut, e.gap);
        checkVal("msgCnt", msgCntOut, e.cnt);
      end
    end
  end

  task automatic slot(input logic v, input logic [7:0] b, input logic lost);
    @(posedge clkIn);
    #1;
    itchDataValidIn = v;
    itchDataIn      = b;
    packetLostIn    = lost;
  endtask

  task automatic idle(input int n);
    repeat (n) slot(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic gaps(input int maxGap);
    idle(int'($urandom_range(maxGap, 0)));
  endtask

  task automatic sendMsg(input logic [15:0] len, input logic [7:0] typ, input int maxGap, input bit lostAtEmit);
    logic [DW-1:0] d;
    logic [7:0]    b;
    int            lastCyc;
    expMsgT        e;
    d = '0;
    lastCyc = 0;
    slot(1'b1, len[15:8], 1'b0);
    gaps(maxGap);
    slot(1'b1, len[7:0], 1'b0);
    gaps(maxGap);
    for (int k = 0; k < int'(len); k++) begin
      b = (k == 0) ? typ : 8'($urandom);
      if (k < MAXB) d[(MAXB-1-k)*8 +: 8] = b;
      slot(1'b1, b, 1'b0);
      if (k == int'(len) - 1) lastCyc = cyc;
      else gaps(maxGap);
    end
    msgExp++;
    e.typ = typ; e.len = len; e.data = d; e.trunc = (int'(len) > MAXB);
    e.gap = gapPend; e.cnt = msgExp; e.cyc = lastCyc + 2;
    expQ.push_back(e);
    gapPend = lostAtEmit;
    if (lostAtEmit) slot(1'b0, 8'h00, 1'b1);
  endtask

  task automatic sendZero(input int maxGap);
    slot(1'b1, 8'h00, 1'b0);
    gaps(maxGap);
    slot(1'b1, 8'h00, 1'b0);
    abortExp++;
  endtask

  task automatic sendPartial(input logic [15:0] len, input int nBody);
    slot(1'b1, len[15:8], 1'b0);
    slot(1'b1, len[7:0], 1'b0);
    for (int k = 0; k < nBody; k++) slot(1'b1, 8'($urandom), 1'b0);
    idle(TMO + 6);
    abortExp++;
  endtask

  task automatic pulseLost();
    slot(1'b0, 8'h00, 1'b1);
    gapPend = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " valid"}, msgValidOut, 0);
    checkVal({tag, " type"}, msgTypeOut, 0);
    checkVal({tag, " len"}, msgLenOut, 0);
    checkVal({tag, " data"}, msgDataOut, 0);
    checkVal({tag, " trunc"}, msgTruncOut, 0);
    checkVal({tag, " gap"}, msgSeqGapOut, 0);
    checkVal({tag, " cnt"}, msgCntOut, 0);
    checkVal({tag, " abort"}, abortCntOut, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clkIn);
    #1;
    checkAllZero("reset");
    rstIn = 1'b0;

    sendMsg(16'd36, 8'h41, 0, 1'b0);
    idle(4);

    sendMsg(16'd12, 8'h44, 0, 1'b0);
    sendMsg(16'd36, 8'h45, 0, 1'b0);
    sendMsg(16'd20, 8'h58, 0, 1'b0);
    idle(4);
    checkVal("msgCnt back-to-back", msgCntOut, msgExp);

    sendMsg(16'd64, 8'h55, 1, 1'b0);
    sendMsg(16'd5, 8'h53, 0, 1'b0);
    sendMsg(16'd50, 8'h41, 0, 1'b0);
    sendMsg(16'd51, 8'h44, 0, 1'b0);
    idle(4);

    sendZero(0);
    sendMsg(16'd3, 8'h41, 0, 1'b0);
    idle(4);
    checkVal("abortCnt zero-len", abortCntOut, abortExp);

    sendPartial(16'd36, 10);
    sendMsg(16'd2, 8'h44, 0, 1'b0);
    idle(4);
    checkVal("abortCnt timeout", abortCntOut, abortExp);

    pulseLost();
    idle(2);
    sendMsg(16'd8, 8'h41, 2, 1'b0);
    sendMsg(16'd9, 8'h45, 2, 1'b0);
    idle(4);

    sendMsg(16'd6, 8'h58, 0, 1'b1);
    sendMsg(16'd7, 8'h55, 0, 1'b0);
    idle(4);

    repeat (40) begin
      int r;
      r = int'($urandom_range(9, 0));
      if (r == 0) sendZero(int'($urandom_range(2, 0)));
      else if (r == 1) begin
        idle(3);
        pulseLost();
      end
      sendMsg(16'($urandom_range(70, 1)), types[$urandom_range(5, 0)],
              int'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0));
    end
    idle(6);
    checkVal("pending msgs", expQ.size(), 0);
    checkVal("msgCnt random", msgCntOut, msgExp);
    checkVal("abortCnt random", abortCntOut, abortExp);

    slot(1'b1, 8'h00, 1'b0);
    slot(1'b1, 8'd30, 1'b0);
    for (int k = 0; k < 5; k++) slot(1'b1, 8'($urandom), 1'b0);
    #2;
    rstIn = 1'b1;
    #1;
    checkAllZero("mid-body reset");
    expQ.delete();
    msgExp = 0;
    abortExp = 0;
    gapPend = 1'b0;
    @(posedge clkIn);
    #1;
    itchDataValidIn = 1'b0;
    rstIn = 1'b0;
    idle(80);
    checkVal("msgCnt after reset", msgCntOut, 0);
    checkVal("abortCnt after reset", abortCntOut, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
